// File: rtl/hamming_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hamming_dec                                                  |
// | Description : Two-stage SECDED decoder for 8/16/32-bit extended Hamming    |
// |               codewords, with saturating single/double error counters.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hamming_dec #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic                          valid_in,
    input  logic [1:0]                    work_mod,
    output logic [MAX_INFO_WIDTH-1:0]     data_out,
    output logic [1:0]                    num_of_errors,
    output logic                          valid_out,
    output logic [15:0]                   single_cnt,
    output logic [15:0]                   double_cnt
);

    localparam int c_SYN_W = $clog2(MAX_CODEWORD_WIDTH);

    // Bit i of the result is set when Hamming position i+1 has bit b set.
    function automatic logic [MAX_CODEWORD_WIDTH-1:0] pos_mask(input int b);
        logic [MAX_CODEWORD_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_CODEWORD_WIDTH; i++) begin
            if ((((i + 1) >> b) & 1) != 0) begin
                m = m | (MAX_CODEWORD_WIDTH'(1) << i);
            end
        end
        return m;
    endfunction

    function automatic int info_pos(input int k);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int i = 0; i < MAX_CODEWORD_WIDTH; i++) begin
            if ((((i + 1) & i) != 0)) begin
                if (n == k) begin
                    pos = i;
                end
                n = n + 1;
            end
        end
        return pos;
    endfunction

    logic [MAX_CODEWORD_WIDTH-1:0] w_len_mask;
    logic [MAX_CODEWORD_WIDTH-1:0] w_cw;
    logic [MAX_CODEWORD_WIDTH-1:0] w_ham;
    logic [c_SYN_W-1:0]            w_syn;
    logic                          w_par;

    logic                          r_v1;
    logic [MAX_CODEWORD_WIDTH-1:0] r_cw;
    logic [1:0]                    r_mode;
    logic [c_SYN_W-1:0]            r_syn;
    logic                          r_par;

    logic                          w_correct;
    logic [MAX_CODEWORD_WIDTH-1:0] w_flip;
    logic [MAX_CODEWORD_WIDTH-1:0] w_fixed;
    logic [MAX_INFO_WIDTH-1:0]     w_info;
    logic [MAX_INFO_WIDTH-1:0]     w_info_mask;
    logic [1:0]                    w_errs;

    always_comb begin
        case (work_mod)
            2'b00:   w_len_mask = MAX_CODEWORD_WIDTH'(8'hFF);
            2'b01:   w_len_mask = MAX_CODEWORD_WIDTH'(16'hFFFF);
            default: w_len_mask = '1;
        endcase
    end

    // Shifting the length mask right drops the overall parity bit N-1.
    assign w_cw  = data_in & w_len_mask;
    assign w_ham = w_cw & (w_len_mask >> 1);
    assign w_par = ^w_cw;

    generate
        for (genvar b = 0; b < c_SYN_W; b++) begin : g_syn
            localparam logic [MAX_CODEWORD_WIDTH-1:0] c_MASK = pos_mask(b);
            assign w_syn[b] = ^(w_ham & c_MASK);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v1   <= 1'b0;
            r_cw   <= '0;
            r_mode <= 2'b00;
            r_syn  <= '0;
            r_par  <= 1'b0;
        end else begin
            r_v1 <= valid_in;
            if (valid_in) begin
                r_cw   <= w_cw;
                r_mode <= work_mod;
                r_syn  <= w_syn;
                r_par  <= w_par;
            end
        end
    end

    assign w_correct = (r_syn != '0) && r_par;

    generate
        for (genvar i = 0; i < MAX_CODEWORD_WIDTH; i++) begin : g_flip
            assign w_flip[i] = w_correct && (r_syn == c_SYN_W'(i + 1));
        end
        for (genvar k = 0; k < MAX_INFO_WIDTH; k++) begin : g_info
            localparam int c_POS = info_pos(k);
            assign w_info[k] = w_fixed[c_POS];
        end
    endgenerate

    assign w_fixed = r_cw ^ w_flip;

    always_comb begin
        case (r_mode)
            2'b00:   w_info_mask = MAX_INFO_WIDTH'(4'hF);
            2'b01:   w_info_mask = MAX_INFO_WIDTH'(11'h7FF);
            default: w_info_mask = '1;
        endcase
    end

    always_comb begin
        if (r_syn == '0) begin
            w_errs = r_par ? 2'd1 : 2'd0;
        end else begin
            w_errs = r_par ? 2'd1 : 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_out     <= 1'b0;
            data_out      <= '0;
            num_of_errors <= 2'd0;
            single_cnt    <= 16'd0;
            double_cnt    <= 16'd0;
        end else begin
            valid_out <= r_v1;
            if (r_v1) begin
                data_out      <= w_info & w_info_mask;
                num_of_errors <= w_errs;
                if ((w_errs == 2'd1) && (single_cnt != 16'hFFFF)) begin
                    single_cnt <= single_cnt + 16'd1;
                end
                if ((w_errs == 2'd2) && (double_cnt != 16'hFFFF)) begin
                    double_cnt <= double_cnt + 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
